// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM states, default kernel and result-width helper for conv3x3_stream.
package conv_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int unsigned DEF_KERNEL [9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
  localparam int NTAPS = 9;
  localparam logic [3:0] NORM_ADDR = 4'd9;
  function automatic int conv_out_w(input int data_w, input int coef_w);
    return data_w + coef_w + 4;
  endfunction
endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: DEPTH-deep circular delay line; dout is the sample written DEPTH accepts ago.
module conv_line_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     ptr;
  assign dout = mem[ptr];
  always_ff @(posedge clk)
    if (en) mem[ptr] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (en) ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
endmodule

// File: rtl/conv3x3_stream.sv
// conv3x3_stream: streaming 3x3 convolution with two line buffers and programmable kernel.
// Optional CONV_NORM_EN adds a right-shift normaliser written at coefficient address 9.
module conv3x3_stream import conv_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    start,
  input  logic                                    coef_we,
  input  logic [3:0]                              coef_addr,
  input  logic [COEF_W-1:0]                       coef_data,
  input  logic                                    s_valid,
  output logic                                    s_ready,
  input  logic [DATA_W-1:0]                       s_data,
  output logic                                    m_valid,
  input  logic                                    m_ready,
  output logic [conv_out_w(DATA_W, COEF_W)-1:0]   m_data,
  output logic                                    m_last,
  output logic                                    busy,
  output logic                                    done
);
  localparam int OUT_W = conv_out_w(DATA_W, COEF_W);
  localparam int PIX   = IMG_W * IMG_H;
  localparam int CW    = $clog2(PIX + 1);
  localparam int XW    = $clog2(IMG_W);
  localparam int YW    = $clog2(IMG_H);
  localparam int PW    = DATA_W + COEF_W;
  state_t            state, state_nx;
  logic [CW-1:0]     in_cnt;
  logic [XW-1:0]     col;
  logic [YW-1:0]     row;
  logic              en, acc, win_ok, frame_last, idle_wr;
  logic [COEF_W-1:0] coef [NTAPS];
  logic [DATA_W-1:0] lb1, lb2;
  logic [DATA_W-1:0] w [3][2];
  logic [DATA_W-1:0] tap [NTAPS];
  logic [PW-1:0]     prod [NTAPS];
  logic              p_valid, p_last;
  logic [OUT_W-1:0]  sum;
  assign en         = !m_valid || m_ready;
  assign s_ready    = (state == RUN) && (in_cnt < CW'(PIX)) && en;
  assign acc        = s_valid && s_ready;
  assign win_ok     = (row >= YW'(2)) && (col >= XW'(2));
  assign frame_last = (row == YW'(IMG_H - 1)) && (col == XW'(IMG_W - 1));
  assign idle_wr    = (state == IDLE) && coef_we;
  conv_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb0 (
    .clk(clk), .rst_n(rst_n), .en(acc), .din(s_data), .dout(lb1)
  );
  conv_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb1 (
    .clk(clk), .rst_n(rst_n), .en(acc), .din(lb1), .dout(lb2)
  );
  // Newest column comes straight from the line buffers and the input, so the
  // products see the full window in the same cycle the completing pixel arrives.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      tap[3*r]   = w[r][0];
      tap[3*r+1] = w[r][1];
    end
    tap[2] = lb2;
    tap[5] = lb1;
    tap[8] = s_data;
  end
  always_comb begin
    sum = '0;
    for (int k = 0; k < NTAPS; k++) sum = sum + OUT_W'(prod[k]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      in_cnt <= '0;
      col    <= '0;
      row    <= '0;
      for (int r = 0; r < 3; r++) begin
        w[r][0] <= '0;
        w[r][1] <= '0;
      end
    end else if ((state == IDLE) && start) begin
      in_cnt <= '0;
      col    <= '0;
      row    <= '0;
    end else if (acc) begin
      in_cnt <= in_cnt + 1'b1;
      col    <= (col == XW'(IMG_W - 1)) ? '0 : col + 1'b1;
      row    <= (col == XW'(IMG_W - 1)) ? row + 1'b1 : row;
      for (int r = 0; r < 3; r++) begin
        w[r][0] <= w[r][1];
        w[r][1] <= tap[3*r+2];
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < NTAPS; k++) coef[k] <= COEF_W'(DEF_KERNEL[k]);
    end else if (idle_wr && (coef_addr < NORM_ADDR)) begin
      coef[coef_addr] <= coef_data;
    end
`ifdef CONV_NORM_EN
  logic [4:0] norm_shift;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) norm_shift <= '0;
    else if (idle_wr && (coef_addr == NORM_ADDR)) norm_shift <= 5'(coef_data);
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p_valid <= 1'b0;
      p_last  <= 1'b0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
      for (int k = 0; k < NTAPS; k++) prod[k] <= '0;
    end else if (en) begin
      p_valid <= acc && win_ok;
      p_last  <= acc && win_ok && frame_last;
      for (int k = 0; k < NTAPS; k++) prod[k] <= PW'(tap[k]) * PW'(coef[k]);
      m_valid <= p_valid;
      m_last  <= p_last;
`ifdef CONV_NORM_EN
      if (p_valid) m_data <= sum >> norm_shift;
`else
      if (p_valid) m_data <= sum;
`endif
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? RUN : IDLE;
      RUN:     state_nx = (m_valid && m_ready && m_last) ? DONE : RUN;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
  end
endmodule
